multdiv_sequencer: RTL

- Execute-stage controller that shares the single iterative multiplier/divider between R-type MUL/DIV instructions and the pipeline.
- Detects MUL/DIV in D/X and launches the multdiv unit with a one-cycle ctrl pulse.
- Stalls PC, F/D and D/X until the result is written back.
- On multdiv exception, steers rstatus (r30) writeback instead of rd.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_sequencer_if.sv | 39 +++
 rtl/multdiv_op_detect.sv | 21 ++
 rtl/multdiv_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants and FSM state type for the MUL/DIV execute-stage sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  localparam logic [4:0] OP_RTYPE     = 5'b00000;
  localparam logic [4:0] MUL_ALUOP    = 5'b00110;
  localparam logic [4:0] DIV_ALUOP    = 5'b00111;
  localparam logic [4:0] RSTATUS_REG  = 5'd30;
  localparam int unsigned RSTATUS_MUL = 4;
  localparam int unsigned RSTATUS_DIV = 5;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline / multdiv / writeback signal bundle seen by the MUL/DIV sequencer.
interface multdiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             x_valid;
  logic [4:0]       x_opcode;
  logic [4:0]       x_aluop;
  logic [4:0]       x_rd;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] x_b;
  logic             md_ctrl_mult;
  logic             md_ctrl_div;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             md_rdy;
  logic             stall;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ack;

  modport master (
    input  x_valid, x_opcode, x_aluop, x_rd, x_a, x_b,
    input  md_result, md_exception, md_rdy, wb_ack,
    output md_ctrl_mult, md_ctrl_div, md_a, md_b,
    output stall, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output x_valid, x_opcode, x_aluop, x_rd, x_a, x_b,
    output md_result, md_exception, md_rdy, wb_ack,
    input  md_ctrl_mult, md_ctrl_div, md_a, md_b,
    input  stall, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/multdiv_op_detect.sv
// Combinational decode of a live R-type MUL or DIV sitting in D/X.
module multdiv_op_detect
  import multdiv_pkg::*;
#(
  parameter logic [4:0] MUL_ALUOP = multdiv_pkg::MUL_ALUOP,
  parameter logic [4:0] DIV_ALUOP = multdiv_pkg::DIV_ALUOP
) (
  input  logic       valid,
  input  logic [4:0] opcode,
  input  logic [4:0] aluop,
  output logic       is_md,
  output logic       is_mul
);

  logic rtype;

  assign rtype  = valid & (opcode == OP_RTYPE);
  assign is_mul = rtype & (aluop == MUL_ALUOP);
  assign is_md  = is_mul | (rtype & (aluop == DIV_ALUOP));

endmodule

// File: rtl/multdiv_sequencer.sv
// Launches the shared multdiv unit for MUL/DIV, stalls the front end and writes back rd or r30.
// Define MULTDIV_WATCHDOG_EN to end BUSY with an exception after MAX_CYCLES without md_rdy.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter logic [4:0]  MUL_ALUOP   = multdiv_pkg::MUL_ALUOP,
  parameter logic [4:0]  DIV_ALUOP   = multdiv_pkg::DIV_ALUOP,
  parameter int unsigned RSTATUS_MUL = multdiv_pkg::RSTATUS_MUL,
  parameter int unsigned RSTATUS_DIV = multdiv_pkg::RSTATUS_DIV,
  parameter int unsigned MAX_CYCLES  = 48,
  parameter int unsigned CNT_W       = 6
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);

  state_t           state, next_state;
  logic             is_md, is_mul;
  logic             op_mul_l, exc_l;
  logic [WIDTH-1:0] a_l, b_l, result_l, rstatus;
  logic [4:0]       rd_l;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max, wb_req, done_exit;

  multdiv_op_detect #(
    .MUL_ALUOP(MUL_ALUOP),
    .DIV_ALUOP(DIV_ALUOP)
  ) u_detect (
    .valid (bus.x_valid),
    .opcode(bus.x_opcode),
    .aluop (bus.x_aluop),
    .is_md (is_md),
    .is_mul(is_mul)
  );

  assign wb_req    = exc_l | (rd_l != '0);
  // A write to r0 has nothing to wait for, so DONE leaves without an ack.
  assign done_exit = (state == DONE) & (~wb_req | bus.wb_ack);
  assign cnt_max   = (cnt == CNT_LIMIT);
  assign rstatus   = op_mul_l ? WIDTH'(RSTATUS_MUL) : WIDTH'(RSTATUS_DIV);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (is_md) next_state = START;
      START: next_state = BUSY;
      BUSY: begin
        if (bus.md_rdy) next_state = DONE;
`ifdef MULTDIV_WATCHDOG_EN
        else if (cnt_max) next_state = DONE;
`endif
      end
      DONE:  if (done_exit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_mul_l <= 1'b0;
      exc_l    <= 1'b0;
      a_l      <= '0;
      b_l      <= '0;
      rd_l     <= '0;
      result_l <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            op_mul_l <= is_mul;
            a_l      <= bus.x_a;
            b_l      <= bus.x_b;
            rd_l     <= bus.x_rd;
          end
        end
        START: begin
          cnt   <= '0;
          exc_l <= 1'b0;
        end
        BUSY: begin
          // Saturate so a stuck unit cannot wrap the counter back to zero.
          if (!cnt_max) cnt <= cnt + 1'b1;
          if (bus.md_rdy) begin
            result_l <= bus.md_result;
            exc_l    <= bus.md_exception;
          end
`ifdef MULTDIV_WATCHDOG_EN
          else if (cnt_max) exc_l <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.md_a         = '0;
    bus.md_b         = '0;
    bus.stall        = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    case (state)
      IDLE: bus.stall = is_md;
      START: begin
        bus.stall        = 1'b1;
        bus.md_ctrl_mult = op_mul_l;
        bus.md_ctrl_div  = ~op_mul_l;
        bus.md_a         = a_l;
        bus.md_b         = b_l;
      end
      BUSY: begin
        bus.stall = 1'b1;
        bus.md_a  = a_l;
        bus.md_b  = b_l;
      end
      DONE: begin
        bus.stall    = ~done_exit;
        bus.md_a     = a_l;
        bus.md_b     = b_l;
        bus.wb_valid = wb_req;
        if (wb_req) begin
          bus.wb_rd   = exc_l ? RSTATUS_REG : rd_l;
          bus.wb_data = exc_l ? rstatus : result_l;
        end
      end
      default: ;
    endcase
  end

endmodule
